// File: rtl/tow_pkg.sv
// Shared encodings for the tug-of-war engine: game state and winner codes.
package tow_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_ARMED = 2'b01,
        ST_WIN   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        W_NONE  = 2'b00,
        W_RIGHT = 2'b01,
        W_LEFT  = 2'b10
    } winner_t;

    // Width needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        cnt_width = (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/tow_timer.sv
// Loadable down-counter with a zero flag; serves the CLEAR dwell and the WIN blink.
module tow_timer #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= RST_VAL;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/tug_of_war_core.sv
// Tug-of-war game engine: rope position, round counting, false-start penalties,
// blank phase between rounds and winner blink, all outputs registered.
module tug_of_war_core
    import tow_pkg::*;
#(
    parameter int NUM_LEDS     = 7,
    parameter int CLEAR_CYCLES = 4,
    parameter int BLINK_CYCLES = 8,
    parameter int RCNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pbl,
    input  logic                pbr,
    input  logic                FTL_Left,
    input  logic                FTL_Right,
    output logic [NUM_LEDS-1:0] leds_out,
    output logic [1:0]          winner,
    output logic [RCNT_W-1:0]   round_cnt,
    output logic                leds_on
);

    localparam int PW   = $clog2(NUM_LEDS);
    localparam int TMAX = (CLEAR_CYCLES > BLINK_CYCLES) ? CLEAR_CYCLES : BLINK_CYCLES;
    localparam int TW   = cnt_width(TMAX - 1);

    localparam logic [PW-1:0] POS_MAX  = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] POS_CTR  = PW'((NUM_LEDS - 1) / 2);
    localparam logic [TW-1:0] CLR_LOAD = TW'(CLEAR_CYCLES - 1);
    localparam logic [TW-1:0] BLK_LOAD = TW'(BLINK_CYCLES - 1);

    state_t              state_r, state_nxt_s;
    winner_t             winner_r, winner_nxt_s;
    logic [PW-1:0]       pos_r, pos_nxt_s;
    logic [RCNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic                blink_r, blink_nxt_s;
    logic [NUM_LEDS-1:0] leds_r, leds_nxt_s;
    logic                leds_on_r;
    logic                resolved_s, fl_s, fr_s;
    logic                tmr_load_s, tmr_zero_s;
    logic [TW-1:0]       tmr_val_s;

    tow_timer #(.W(TW), .RST_VAL(CLR_LOAD)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, position, round count and timer control for one game-clock step.
    always_comb begin
        state_nxt_s  = state_r;
        winner_nxt_s = winner_r;
        pos_nxt_s    = pos_r;
        cnt_nxt_s    = cnt_r;
        blink_nxt_s  = blink_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = CLR_LOAD;
        resolved_s   = 1'b0;
        fl_s         = pbl & FTL_Left;
        fr_s         = pbr & FTL_Right;

        case (state_r)
            ST_CLEAR: begin
                if (fl_s && !fr_s) begin
                    pos_nxt_s  = pos_r - PW'(1'b1);
                    resolved_s = 1'b1;
                end else if (fr_s && !fl_s) begin
                    pos_nxt_s  = pos_r + PW'(1'b1);
                    resolved_s = 1'b1;
                end else if (tmr_zero_s) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_ARMED: begin
                if (pbl || pbr) begin
                    resolved_s  = 1'b1;
                    state_nxt_s = ST_CLEAR;
                    if (pbl && !pbr) begin
                        pos_nxt_s = pos_r + PW'(1'b1);
                    end else if (pbr && !pbl) begin
                        pos_nxt_s = pos_r - PW'(1'b1);
                    end else begin
                        pos_nxt_s = pos_r;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_WIN: begin
                // Terminal: only the blink phase advances.
                if (tmr_zero_s) begin
                    blink_nxt_s = ~blink_r;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = BLK_LOAD;
                end else begin
                    blink_nxt_s = blink_r;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase

        // A resolved round counts, restarts the dwell, and may end the game.
        if (resolved_s) begin
            cnt_nxt_s  = (cnt_r == {RCNT_W{1'b1}}) ? cnt_r : cnt_r + RCNT_W'(1'b1);
            tmr_load_s = 1'b1;
            if (pos_nxt_s == POS_MAX) begin
                state_nxt_s  = ST_WIN;
                winner_nxt_s = W_LEFT;
                blink_nxt_s  = 1'b1;
                tmr_val_s    = BLK_LOAD;
            end else if (pos_nxt_s == {PW{1'b0}}) begin
                state_nxt_s  = ST_WIN;
                winner_nxt_s = W_RIGHT;
                blink_nxt_s  = 1'b1;
                tmr_val_s    = BLK_LOAD;
            end else begin
                tmr_val_s = CLR_LOAD;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if ((state_nxt_s == ST_ARMED) || ((state_nxt_s == ST_WIN) && blink_nxt_s)) begin
            leds_nxt_s = NUM_LEDS'(1'b1) << pos_nxt_s;
        end else begin
            leds_nxt_s = {NUM_LEDS{1'b0}};
        end
    end

    // Game state and all registered outputs; reset aborts any game in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            winner_r  <= W_NONE;
            pos_r     <= POS_CTR;
            cnt_r     <= {RCNT_W{1'b0}};
            blink_r   <= 1'b0;
            leds_r    <= {NUM_LEDS{1'b0}};
            leds_on_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            winner_r  <= winner_nxt_s;
            pos_r     <= pos_nxt_s;
            cnt_r     <= cnt_nxt_s;
            blink_r   <= blink_nxt_s;
            leds_r    <= leds_nxt_s;
            leds_on_r <= (state_nxt_s != ST_CLEAR);
        end
    end

    assign leds_out  = leds_r;
    assign winner    = winner_r;
    assign round_cnt = cnt_r;
    assign leds_on   = leds_on_r;

endmodule
